vga_scanout: RTL



---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing.sv | 30 +++
 rtl/vga_scanout.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Timing constants and shared types for the 640x480@60 VGA scanout path.
package vga_pkg;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_TOT  = 10'd800;

  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_TOT  = 10'd525;

  localparam logic [3:0] SCALE          = 4'd10;
  localparam logic [6:0] FB_W           = 7'd64;
  localparam logic [5:0] FB_H           = 6'd48;
  localparam logic [1:0] WORDS_PER_LINE = 2'd2;

  localparam logic [3:0] SCALE_LAST = SCALE - 4'd1;
  localparam logic [5:0] XCOL_LAST  = 6'(FB_W - 7'd1);
  localparam logic [5:0] YROW_LAST  = FB_H - 6'd1;

  // va is loaded one cycle before it must be seen, which is two cycles before the pixel.
  localparam logic [9:0] FETCH0_H = H_TOT - 10'd3;
  localparam logic [9:0] FETCH1_H = (H_VIS >> 1) - 10'd3;

  typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 raster counters with raw (unregistered) sync and visible flags.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOT - 10'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOT - 10'd1) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hsync_raw = !((hcnt >= H_VIS + H_FP) && (hcnt < H_VIS + H_FP + H_SYNC));
  assign vsync_raw = !((vcnt >= V_VIS + V_FP) && (vcnt < V_VIS + V_FP + V_SYNC));

endmodule

// File: rtl/vga_scanout.sv
// 64x48 1bpp framebuffer scanout, 10x magnified, with registered VGA outputs.
// Optional VGA_TEST_PATTERN_EN adds a test_mode input selecting a generated pattern.
module vga_scanout
  import vga_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h0000_0600,
  parameter rgb12_t      FG_RGB  = 12'hFFF,
  parameter rgb12_t      BG_RGB  = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [31:0] va,
  input  logic [31:0] vd,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  logic [9:0]  hcnt, vcnt;
  logic        visible, hsync_raw, vsync_raw;
  logic [3:0]  xsub, ysub;
  logic [5:0]  xcol, yrow, next_yrow;
  logic [31:0] pix_q;
  logic        line_vis, word0_line, fetch0, fetch1, latch0, latch1;
  logic [6:0]  fetch_word;
  rgb12_t      pix_rgb, rgb_q;

  vga_timing u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  assign line_vis = vcnt < V_VIS;

  // Row shown on the next line; word 0 of that line is fetched at the end of this one.
  always_comb begin
    next_yrow = yrow;
    if (line_vis && (ysub == SCALE_LAST))
      next_yrow = (yrow == YROW_LAST) ? '0 : yrow + 6'd1;
  end

  // Video port: va is registered, memory samples it, vd is valid one clock later and
  // is captured only in the cycle after a fetch slot; any other vd is ignored.
  assign word0_line = (vcnt == V_TOT - 10'd1) || (vcnt < V_VIS - 10'd1);
  assign fetch0     = (hcnt == FETCH0_H) && word0_line;
  assign fetch1     = (hcnt == FETCH1_H) && line_vis;
  assign latch0     = (hcnt == FETCH0_H + 10'd2) && word0_line;
  assign latch1     = (hcnt == FETCH1_H + 10'd2) && line_vis;
  assign fetch_word = fetch0 ? ((7'(next_yrow) << 1) | 7'd0) : ((7'(yrow) << 1) | 7'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      va    <= FB_BASE;
      pix_q <= '0;
    end else begin
      if (fetch0 || fetch1)
        va <= FB_BASE + {23'd0, fetch_word, 2'b00};
      if (latch0 || latch1)
        pix_q <= vd;
      else if (visible && (xsub == SCALE_LAST))
        pix_q <= {1'b0, pix_q[31:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xsub <= '0;
      xcol <= '0;
      ysub <= '0;
      yrow <= '0;
    end else begin
      if (visible) begin
        if (xsub == SCALE_LAST) begin
          xsub <= '0;
          xcol <= (xcol == XCOL_LAST) ? '0 : xcol + 6'd1;
        end else begin
          xsub <= xsub + 4'd1;
        end
      end
      if (line_vis && (hcnt == H_TOT - 10'd1)) begin
        ysub <= (ysub == SCALE_LAST) ? '0 : ysub + 4'd1;
        yrow <= next_yrow;
      end
    end
  end

  always_comb begin
    pix_rgb = pix_q[0] ? FG_RGB : BG_RGB;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode)
      pix_rgb = {xcol[5:2], yrow[5:2], xcol[3:0] ^ yrow[3:0]};
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_raw;
      vsync       <= vsync_raw;
      rgb_q       <= visible ? pix_rgb : '0;
      frame_start <= (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule
